// File: rtl/load_unit_pkg.sv
// ---------------------------------------------------------------------------
// load_unit_pkg
// Shared definitions for the load datapath stage:
//   - MIPS I-type load opcodes (lb, lh, lw, lbu, lhu)
//   - FSM state encoding
//   - default memory-ready timeout
//   - small decode helpers for opcode legality and address alignment
// ---------------------------------------------------------------------------
package load_unit_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;

  localparam int DEFAULT_TIMEOUT = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    MEM  = 3'd2,
    WB   = 3'd3,
    ERR  = 3'd4
  } state_t;

  // True for the five supported load opcodes.
  function automatic logic is_load_op(input logic [5:0] op);
    logic v;
    v = (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
        (op == OP_LBU) || (op == OP_LHU);
    return v;
  endfunction

  // Natural alignment: words on 4-byte, halves on 2-byte boundaries.
  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] lane);
    logic v;
    v = 1'b0;
    case (op)
      OP_LW:         v = (lane != 2'b00);
      OP_LH, OP_LHU: v = lane[0];
      default:       v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/load_extend.sv
// ---------------------------------------------------------------------------
// load_extend
// Purely combinational lane select and extension of a little-endian memory
// word for the load opcodes.
// Ports:
//   i_word   [31:0]  word returned by memory
//   i_addr   [1:0]   low effective-address bits (byte lane / half lane)
//   i_opcode [5:0]   load opcode
//   o_data   [31:0]  extended register write data
// ---------------------------------------------------------------------------
module load_extend
  import load_unit_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr,
  input  logic [5:0]  i_opcode,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_addr)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
  end

  assign w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_data = i_word;
    case (i_opcode)
      OP_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_data = {24'd0, w_byte};
      OP_LH:   o_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_data = {16'd0, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// ---------------------------------------------------------------------------
// load_unit
// Multi-cycle load stage: decodes a MIPS I-type load, forms rs + sext(imm16),
// reads a word from data memory with a ready handshake, extracts/extends the
// addressed byte/half/word and issues a single-cycle register-file write.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   start        request, sampled only in IDLE
//   instruction  load instruction ([31:26] opcode, [20:16] rt, [15:0] imm16)
//   Read_data1   rs value (base address)
//   mem_rdata    memory read word, valid with mem_ready
//   mem_ready    memory read-data-valid strobe
//   MemRead      memory read request, high for the whole MEM state
//   mem_addr     word-aligned read address
//   ALU_result   registered effective address
//   RegWrite     register-file write enable (one cycle)
//   Write_reg    destination register (rt)
//   Write_data   extended load data
//   busy         high whenever not IDLE
//   done         one-cycle completion pulse
//   error        one-cycle pulse with done on illegal/misaligned/timeout
//
// Flow: IDLE -> ADDR -> MEM -> WB -> IDLE, with ADDR or MEM diverting to ERR.
// With mem_ready on the first MEM cycle, done is high in the third cycle after
// the cycle in which start is presented.
// ---------------------------------------------------------------------------
module load_unit
  import load_unit_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int TO_W    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] instruction,
  input  logic [31:0] Read_data1,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        MemRead,
  output logic [31:0] mem_addr,
  output logic [31:0] ALU_result,
  output logic        RegWrite,
  output logic [4:0]  Write_reg,
  output logic [31:0] Write_data,
  output logic        busy,
  output logic        done,
  output logic        error
);

  state_t            r_state;
  state_t            w_state_next;
  logic [5:0]        r_opcode;
  logic [4:0]        r_rt;
  logic [TO_W-1:0]   r_to_cnt;
  logic [31:0]       r_alu_result;
  logic [4:0]        r_write_reg;
  logic [31:0]       r_write_data;

  logic [31:0]       w_imm_sext;
  logic [31:0]       w_eff_addr;
  logic              w_fault;
  logic [TO_W-1:0]   w_to_cnt_inc;
  logic [31:0]       w_ext_data;
  logic              w_unused;

  // rs field arrives already resolved through Read_data1.
  assign w_unused = &{1'b0, instruction[25:21]};

  // Effective address; carry out of bit 31 is discarded.
  assign w_imm_sext = {{16{instruction[15]}}, instruction[15:0]};
  assign w_eff_addr = Read_data1 + w_imm_sext;

  assign w_fault      = !is_load_op(r_opcode) || is_misaligned(r_opcode, w_eff_addr[1:0]);
  assign w_to_cnt_inc = r_to_cnt + 1'b1;

  load_extend u_extend (
    .i_word   (mem_rdata),
    .i_addr   (r_alu_result[1:0]),
    .i_opcode (r_opcode),
    .o_data   (w_ext_data)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_opcode     <= '0;
      r_rt         <= '0;
      r_to_cnt     <= '0;
      r_alu_result <= '0;
      r_write_reg  <= '0;
      r_write_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_opcode <= instruction[31:26];
            r_rt     <= instruction[20:16];
          end
        end
        ADDR: begin
          // Address is recorded even when the access faults.
          r_alu_result <= w_eff_addr;
          r_to_cnt     <= '0;
        end
        MEM: begin
          if (mem_ready) begin
            r_write_data <= w_ext_data;
            r_write_reg  <= r_rt;
          end else begin
            r_to_cnt <= w_to_cnt_inc;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    w_state_next = r_state;
    MemRead      = 1'b0;
    RegWrite     = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    error        = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_next = ADDR;
        end
      end
      ADDR: begin
        w_state_next = w_fault ? ERR : MEM;
      end
      MEM: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          w_state_next = WB;
        end else if (w_to_cnt_inc == TO_W'(TIMEOUT)) begin
          // TIMEOUT MEM cycles have elapsed without ready.
          w_state_next = ERR;
        end
      end
      WB: begin
        done         = 1'b1;
        RegWrite     = (r_rt != 5'd0);
        w_state_next = IDLE;
      end
      ERR: begin
        done         = 1'b1;
        error        = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign mem_addr   = {r_alu_result[31:2], 2'b00};
  assign ALU_result = r_alu_result;
  assign Write_reg  = r_write_reg;
  assign Write_data = r_write_data;

endmodule

// File: tb/tb_load_unit.sv
module tb_load_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] instruction;
  logic [31:0] Read_data1;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        MemRead;
  logic [31:0] mem_addr;
  logic [31:0] ALU_result;
  logic        RegWrite;
  logic [4:0]  Write_reg;
  logic [31:0] Write_data;
  logic        busy;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;

  // Observations from the most recent run_load call
  int          o_done_cyc;
  int          o_memread_cyc;
  int          o_rw_cnt;
  logic [4:0]  o_rw_reg;
  logic [31:0] o_wdata;
  logic        o_err;
  logic [31:0] o_addr;
  logic [31:0] o_alu;

  load_unit #(.TIMEOUT(16), .TO_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .instruction (instruction),
    .Read_data1  (Read_data1),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .MemRead     (MemRead),
    .mem_addr    (mem_addr),
    .ALU_result  (ALU_result),
    .RegWrite    (RegWrite),
    .Write_reg   (Write_reg),
    .Write_data  (Write_data),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one load (start presented for one cycle) and records what the DUT
  // shows per cycle. Cycle k=1 is the cycle after the start edge. mem_ready is
  // raised from cycle ready_at onward. Bounded at 40 cycles; done_cyc=-1 if
  // done never appears.
  task automatic run_load(input logic [5:0] op, input logic [4:0] rt,
                          input logic [31:0] rs, input logic [15:0] imm,
                          input logic [31:0] rdata, input int ready_at);
    @(negedge clk);
    instruction = {op, 5'd3, rt, imm};
    Read_data1  = rs;
    mem_rdata   = rdata;
    mem_ready   = 1'b0;
    start       = 1'b1;
    o_done_cyc = -1; o_memread_cyc = 0; o_rw_cnt = 0;
    o_rw_reg = '0; o_wdata = '0; o_err = 1'b0; o_addr = '0; o_alu = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (MemRead) begin
        o_memread_cyc++;
        o_addr = mem_addr;
      end
      if (RegWrite) begin
        o_rw_cnt++;
        o_rw_reg = Write_reg;
      end
      if (done) begin
        o_done_cyc = k;
        o_err      = error;
        o_wdata    = Write_data;
        o_alu      = ALU_result;
        break;
      end
      mem_ready = (k >= ready_at);
    end
    mem_ready = 1'b0;
    $display("load op=%h rt=%0d rs=%h imm=%h -> done_cyc=%0d err=%0b wdata=%h rw=%0d/%0d memread=%0d alu=%h",
             op, rt, rs, imm, o_done_cyc, o_err, o_wdata, o_rw_cnt, o_rw_reg, o_memread_cyc, o_alu);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0; instruction = '0; Read_data1 = '0; mem_rdata = '0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({MemRead, RegWrite, busy, done, error} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 00000", {MemRead, RegWrite, busy, done, error});
    end
    checks++;
    if ({mem_addr, ALU_result, Write_data, Write_reg} !== 101'd0) begin
      errors++;
      $display("FAIL reset_data got addr=%h alu=%h wd=%h wr=%0d exp all zero",
               mem_addr, ALU_result, Write_data, Write_reg);
    end
    reset = 1'b1;
    @(negedge clk);
    $display("reset released busy=%0b", busy);
  endtask

  task automatic test_lw();
    run_load(6'h23, 5'd8, 32'h0000_1000, 16'h0004, 32'hDEAD_BEEF, 2);
    checks++;
    if (o_addr !== 32'h0000_1004) begin errors++; $display("FAIL lw_addr got %h exp 00001004", o_addr); end
    checks++;
    if (o_done_cyc !== 3) begin errors++; $display("FAIL lw_latency got %0d exp 3", o_done_cyc); end
    checks++;
    if (o_rw_cnt !== 1 || o_rw_reg !== 5'd8) begin
      errors++; $display("FAIL lw_regwrite got cnt=%0d reg=%0d exp cnt=1 reg=8", o_rw_cnt, o_rw_reg);
    end
    checks++;
    if (o_wdata !== 32'hDEAD_BEEF || o_err !== 1'b0) begin
      errors++; $display("FAIL lw_data got %h err=%0b exp deadbeef err=0", o_wdata, o_err);
    end
    checks++;
    if (o_memread_cyc !== 1) begin errors++; $display("FAIL lw_memread got %0d exp 1", o_memread_cyc); end
  endtask

  task automatic test_extend();
    logic [5:0]  ops   [4] = '{6'h20, 6'h24, 6'h25, 6'h21};
    logic [15:0] imms  [4] = '{16'h0003, 16'h0003, 16'h0002, 16'h0000};
    logic [31:0] exps  [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_8011, 32'h0000_2233};
    for (int i = 0; i < 4; i++) begin
      run_load(ops[i], 5'd9, 32'h0000_1000, imms[i], 32'h8011_2233, 2);
      checks++;
      if (o_wdata !== exps[i] || o_err !== 1'b0) begin
        errors++; $display("FAIL extend_%0d got %h err=%0b exp %h err=0", i, o_wdata, o_err, exps[i]);
      end
    end
    // Delayed ready: three MEM cycles before data is accepted.
    run_load(6'h24, 5'd10, 32'h0000_2001, 16'h0000, 32'h0000_5A00, 4);
    checks++;
    if (o_done_cyc !== 5 || o_memread_cyc !== 3 || o_wdata !== 32'h0000_005A) begin
      errors++; $display("FAIL delayed_ready got cyc=%0d memread=%0d wd=%h exp 5/3/0000005a",
                         o_done_cyc, o_memread_cyc, o_wdata);
    end
  endtask

  task automatic test_misalign();
    // Previous successful load left Write_data = 0000005a.
    run_load(6'h23, 5'd8, 32'h0000_1000, 16'hFFFE, 32'h1111_1111, 2);
    checks++;
    if (o_alu !== 32'h0000_0FFE) begin errors++; $display("FAIL misalign_alu got %h exp 00000ffe", o_alu); end
    checks++;
    if (o_err !== 1'b1 || o_done_cyc !== 2 || o_memread_cyc !== 0 || o_rw_cnt !== 0) begin
      errors++; $display("FAIL misalign_err got err=%0b cyc=%0d memread=%0d rw=%0d exp 1/2/0/0",
                         o_err, o_done_cyc, o_memread_cyc, o_rw_cnt);
    end
    checks++;
    if (o_wdata !== 32'h0000_005A) begin errors++; $display("FAIL misalign_wdata got %h exp 0000005a", o_wdata); end
    // lh at odd address
    run_load(6'h21, 5'd8, 32'h0000_1001, 16'h0000, 32'h1111_1111, 2);
    checks++;
    if (o_err !== 1'b1 || o_memread_cyc !== 0) begin
      errors++; $display("FAIL misalign_lh got err=%0b memread=%0d exp 1/0", o_err, o_memread_cyc);
    end
  endtask

  task automatic test_timeout();
    run_load(6'h23, 5'd7, 32'h0000_2000, 16'h0000, 32'hCAFE_F00D, 1000);
    checks++;
    if (o_memread_cyc !== 16) begin errors++; $display("FAIL timeout_memread got %0d exp 16", o_memread_cyc); end
    checks++;
    if (o_err !== 1'b1 || o_done_cyc !== 18 || o_rw_cnt !== 0) begin
      errors++; $display("FAIL timeout_err got err=%0b cyc=%0d rw=%0d exp 1/18/0", o_err, o_done_cyc, o_rw_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    @(negedge clk);
    instruction = {6'h23, 5'd3, 5'd6, 16'h0000};
    Read_data1  = 32'h0000_4000;
    mem_ready   = 1'b0;
    start       = 1'b1;
    @(negedge clk); start = 1'b0;   // ADDR
    @(negedge clk);                 // MEM wait cycle 1
    @(negedge clk);                 // MEM wait cycle 2
    checks++;
    if (MemRead !== 1'b1) begin errors++; $display("FAIL midreset_pre got MemRead=%0b exp 1", MemRead); end
    reset = 1'b0;
    #1;
    checks++;
    if ({MemRead, RegWrite, busy, done, error} !== 5'b0 || mem_addr !== 32'd0 || ALU_result !== 32'd0) begin
      errors++; $display("FAIL midreset_out got ctrl=%b addr=%h alu=%h exp 0/0/0",
                         {MemRead, RegWrite, busy, done, error}, mem_addr, ALU_result);
    end
    bad = 0;
    mem_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done || RegWrite) bad++;
    end
    mem_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    if (done || RegWrite) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL midreset_pulse got %0d pulses exp 0", bad); end
    $display("mid-op reset done, pulses=%0d", bad);
    run_load(6'h23, 5'd5, 32'h0000_3000, 16'h0008, 32'h1234_5678, 2);
    checks++;
    if (o_done_cyc !== 3 || o_rw_reg !== 5'd5 || o_wdata !== 32'h1234_5678 || o_err !== 1'b0) begin
      errors++; $display("FAIL midreset_after got cyc=%0d reg=%0d wd=%h err=%0b exp 3/5/12345678/0",
                         o_done_cyc, o_rw_reg, o_wdata, o_err);
    end
  endtask

  task automatic test_rt0_illegal();
    run_load(6'h23, 5'd0, 32'h0000_1000, 16'h0000, 32'hAAAA_5555, 2);
    checks++;
    if (o_done_cyc !== 3 || o_rw_cnt !== 0 || o_err !== 1'b0) begin
      errors++; $display("FAIL rt0 got cyc=%0d rw=%0d err=%0b exp 3/0/0", o_done_cyc, o_rw_cnt, o_err);
    end
    run_load(6'h2B, 5'd4, 32'h0000_1000, 16'h0000, 32'hAAAA_5555, 2);
    checks++;
    if (o_err !== 1'b1 || o_done_cyc !== 2 || o_memread_cyc !== 0 || o_rw_cnt !== 0) begin
      errors++; $display("FAIL illegal got err=%0b cyc=%0d memread=%0d rw=%0d exp 1/2/0/0",
                         o_err, o_done_cyc, o_memread_cyc, o_rw_cnt);
    end
  endtask

  task automatic test_back_to_back();
    // run_load presents start in the cycle right after the previous done.
    run_load(6'h25, 5'd11, 32'h0000_0100, 16'h0002, 32'hFEDC_BA98, 2);
    run_load(6'h20, 5'd12, 32'h0000_0100, 16'h0001, 32'hFEDC_BA98, 2);
    checks++;
    if (o_done_cyc !== 3 || o_wdata !== 32'hFFFF_FFBA || o_rw_reg !== 5'd12) begin
      errors++; $display("FAIL b2b got cyc=%0d wd=%h reg=%0d exp 3/ffffffba/12", o_done_cyc, o_wdata, o_rw_reg);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_extend();
    test_misalign();
    test_timeout();
    test_reset_mid();
    test_rt0_illegal();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Multi-cycle load (memory-read) datapath stage; the read-side counterpart of the store path in the execution cycle.
- Decodes MIPS I-type loads (lb, lh, lw, lbu, lhu) and computes the effective address rs + sign-extended imm16.
- Issues a word read to data memory with a ready handshake, then extracts and extends the byte/half/word.
- Drives a one-cycle register-file write for rt.

Parameters:
- TIMEOUT, 16, max cycles waiting for mem_ready in MEM before aborting with error.
- TO_W, 5, timeout counter width; must satisfy 2**TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- instruction  in  32  load instruction; [31:26] opcode, [20:16] rt, [15:0] imm16
- Read_data1  in  32  rs value (base address)
- mem_rdata  in  32  word returned by memory; valid when mem_ready=1
- mem_ready  in  1  memory read-data-valid strobe
- MemRead  out  1  memory read request; held high for all of MEM
- mem_addr  out  32  word-aligned address {ALU_result[31:2],2'b00}
- ALU_result  out  32  registered effective address
- RegWrite  out  1  register-file write enable, one-cycle pulse
- Write_reg  out  5  destination register (rt)
- Write_data  out  32  extended load data
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle completion pulse (success or error)
- error  out  1  one-cycle pulse with done on misalign/illegal/timeout

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0; timeout counter 0.
- Opcodes: lb=6'h20, lh=6'h21, lw=6'h23, lbu=6'h24, lhu=6'h25. Any other opcode is illegal.
- Little-endian lane select: byte lane = addr[1:0]; half lane = addr[1].
- IDLE: when start=1 at a clock edge, latch opcode and rt, then go to ADDR. start in other states is ignored; no queueing.
- ADDR (one cycle): ALU_result <= Read_data1 + sext(imm16), 32-bit modulo with wrap ignored. Check legality and alignment: lw needs addr[1:0]=0; lh/lhu need addr[0]=0.
  - Any violation -> ERR.
  - Otherwise -> MEM, with the counter cleared.
- MEM:
  - MemRead=1 and mem_addr stable.
  - If mem_ready=1 at an edge: capture the extended data into Write_data, then go to WB.
  - Otherwise increment the counter. When the counter reaches TIMEOUT with no mem_ready -> ERR.
  - mem_ready outside MEM is ignored.
- WB (one cycle):
  - done=1.
  - RegWrite=1 and Write_reg=rt, unless rt=0. For rt=0, RegWrite stays 0 and done still pulses.
  - Then go to IDLE.
- ERR (one cycle): done=1, error=1, RegWrite=0, Write_data unchanged. Then go to IDLE.
- Extension:
  - lb: sign-extend the selected byte.
  - lbu: zero-extend the selected byte.
  - lh: sign-extend the selected half.
  - lhu: zero-extend the selected half.
  - lw: full word.
- Latency: with mem_ready high on the first MEM cycle, done rises 3 cycles after the start edge. A back-to-back start is accepted on the cycle after done.
- Reset mid-operation: immediate return to IDLE; no RegWrite or done pulse is produced.
- ALU_result, Write_reg and Write_data hold their values in IDLE until the next operation updates them.

Decomposition:
- Shared package holds:
  - opcode constants OP_LB/OP_LH/OP_LW/OP_LBU/OP_LHU;
  - state enum IDLE/ADDR/MEM/WB/ERR (3 bits);
  - the TIMEOUT default.
- One natural sub-module, load_extend: purely combinational; takes (word, addr[1:0], opcode) and returns 32-bit data.
- The existing sign-extend and ALU blocks are reused for imm16 and the address add.

Test Plan:
- lw, rs=0x1000, imm=0x0004, rt=8, mem_rdata=0xDEADBEEF, ready on 1st MEM cycle -> mem_addr=0x1004; RegWrite pulse with Write_reg=8, Write_data=0xDEADBEEF; done at start+3.
- lb, addr=0x1003, mem_rdata=0x80112233 -> Write_data=0xFFFFFF80. lbu, same inputs -> 0x00000080. lhu, addr=0x1002 -> 0x00008011. lh, addr=0x1000 -> 0x00002233.
- lw, rs=0x1000, imm=0xFFFE (-2) -> ALU_result=0x00000FFE, misaligned. Response: ERR with done=1, error=1, RegWrite=0, and MemRead never asserted.
- lw with mem_ready held low -> MemRead high for TIMEOUT=16 cycles, then error+done, with no RegWrite.
- Reset pulled low during MEM (cycle 2 of wait) -> all outputs 0 immediately. After release, a new lw completes normally.
- lw with rt=0 -> done pulses and RegWrite stays 0. Opcode 6'h2B (sw) -> error.
